// File: rtl/pipeline_pkg.sv
// Shared encodings for the pipeline hazard unit: forwarding selects,
// the PC register number and the data-memory wait FSM states.
package pipeline_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;  // operand from register file
    localparam logic [1:0] FWD_W  = 2'b01;  // operand from ResultW
    localparam logic [1:0] FWD_M  = 2'b10;  // operand from ALUResultM

    // R15 reads return PC+8, never a forwarded result
    localparam logic [3:0] R15 = 4'd15;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    // Forwarding select for one Execute-stage source; Memory beats Writeback
    function automatic logic [1:0] fwd_sel(
        input logic       reg_write_m,
        input logic [3:0] wa3_m,
        input logic       reg_write_w,
        input logic [3:0] wa3_w,
        input logic [3:0] ra
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (ra != R15) begin
            if (reg_write_m && (wa3_m == ra)) begin
                sel = FWD_M;
            end else if (reg_write_w && (wa3_w == ra)) begin
                sel = FWD_W;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts cycles with inc high, sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Increment on inc unless already saturated
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Hazard unit for the 5-stage ARM pipeline: operand forwarding, load-use
// and PC-write stalls, branch flushes, a data-memory wait FSM with timeout,
// and saturating stall/flush event counters.
//
// Memory handshake: MemReqM acts as valid and MemReadyM as ready. An access
// completes in the cycle both are high; while MemReqM is high and MemReadyM
// is low the whole pipeline is frozen (F/D/E/M held, W bubbled). Once a
// wait has started, release depends only on MemReadyM or the timeout.
module hazard_unit
    import pipeline_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       RA1D,
    input  logic [3:0]       RA2D,
    input  logic [3:0]       RA1E,
    input  logic [3:0]       RA2E,
    input  logic [3:0]       WA3E,
    input  logic [3:0]       WA3M,
    input  logic [3:0]       WA3W,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             PCWrPendingF,
    input  logic             PCSrcW,
    input  logic             BranchTakenE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount,
    output logic             MemState
);

    localparam int             WCW       = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

    mem_state_t     state;
    logic [WCW-1:0] waitcnt;
    logic           timeout_hit;
    logic           ldr_stall;
    logic           memstall;

    assign timeout_hit = (waitcnt == WAIT_LAST);
    assign ldr_stall   = MemtoRegE && ((RA1D == WA3E) || (RA2D == WA3E));
    assign MemState    = (state == WAIT);

    // Memory stall: a new unfinished access, or an ongoing wait not yet timed out
    always_comb begin
        memstall = 1'b0;
        case (state)
            RUN:     memstall = MemReqM && !MemReadyM;
            WAIT:    memstall = !MemReadyM && !timeout_hit;
            default: memstall = 1'b0;
        endcase
    end

    // Forwarding, stall and flush controls; reset forces bubbles everywhere
    always_comb begin
        ForwardAE = fwd_sel(RegWriteM, WA3M, RegWriteW, WA3W, RA1E);
        ForwardBE = fwd_sel(RegWriteM, WA3M, RegWriteW, WA3W, RA2E);
        if (memstall) begin
            // Frozen branch/load keep their state and re-evaluate after release
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushD = 1'b0;
            FlushE = 1'b0;
            FlushW = 1'b1;
        end else begin
            StallF = (ldr_stall || PCWrPendingF) && !BranchTakenE;
            StallD = ldr_stall && !BranchTakenE;
            StallE = 1'b0;
            StallM = 1'b0;
            FlushD = PCWrPendingF || PCSrcW || BranchTakenE;
            FlushE = ldr_stall || BranchTakenE;
            FlushW = 1'b0;
        end
        if (!reset) begin
            ForwardAE = FWD_RF;
            ForwardBE = FWD_RF;
            StallF    = 1'b0;
            StallD    = 1'b0;
            StallE    = 1'b0;
            StallM    = 1'b0;
            FlushD    = 1'b1;
            FlushE    = 1'b1;
            FlushW    = 1'b1;
        end
    end

    // Memory wait FSM with cycle counter and sticky timeout error
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= RUN;
            waitcnt <= '0;
            MemErr  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (MemReqM && !MemReadyM) begin
                        state   <= WAIT;
                        waitcnt <= '0;
                    end
                end
                WAIT: begin
                    waitcnt <= waitcnt + WCW'(1);
                    if (MemReadyM) begin
                        state <= RUN;
                    end else if (timeout_hit) begin
                        state  <= RUN;
                        MemErr <= 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (reset),
        .inc   (StallF),
        .count (StallCount)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (reset),
        .inc   (FlushE),
        .count (FlushCount)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: a default instance (MEM_TIMEOUT=16, CNT_W=16) and a
// small instance (MEM_TIMEOUT=4, CNT_W=4) share the same stimulus.
module tb_hazard_unit;

    typedef struct {
        logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
        logic regwritem, regwritew, memtorege, pcwrpendingf;
        logic pcsrcw, branchtakene, memreqm, memreadym;
    } in_t;

    typedef struct {
        in_t        in;
        logic [12:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] RA1D = '0, RA2D = '0, RA1E = '0, RA2E = '0;
    logic [3:0] WA3E = '0, WA3M = '0, WA3W = '0;
    logic       RegWriteM = 0, RegWriteW = 0, MemtoRegE = 0, PCWrPendingF = 0;
    logic       PCSrcW = 0, BranchTakenE = 0, MemReqM = 0, MemReadyM = 0;

    logic [1:0]  ForwardAE, ForwardBE;
    logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr, MemState;
    logic [15:0] StallCount, FlushCount;

    logic [1:0]  ForwardAE_s, ForwardBE_s;
    logic        StallF_s, StallD_s, StallE_s, StallM_s, FlushD_s, FlushE_s, FlushW_s;
    logic        MemErr_s, MemState_s;
    logic [3:0]  StallCount_s, FlushCount_s;

    logic [12:0] act;
    logic [12:0] exp_q[$];
    int          checks = 0;
    int          fails = 0;
    int          exp_stall = 0;
    int          exp_flush = 0;

    // {MemState, ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr}
    assign act = {MemState, ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
                  FlushD, FlushE, FlushW, MemErr};

    hazard_unit dut (
        .clk(clk), .reset(reset),
        .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
        .PCWrPendingF(PCWrPendingF), .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .MemErr(MemErr),
        .StallCount(StallCount), .FlushCount(FlushCount), .MemState(MemState)
    );

    hazard_unit #(.MEM_TIMEOUT(4), .CNT_W(4)) dut_s (
        .clk(clk), .reset(reset),
        .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
        .PCWrPendingF(PCWrPendingF), .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .ForwardAE(ForwardAE_s), .ForwardBE(ForwardBE_s),
        .StallF(StallF_s), .StallD(StallD_s), .StallE(StallE_s), .StallM(StallM_s),
        .FlushD(FlushD_s), .FlushE(FlushE_s), .FlushW(FlushW_s), .MemErr(MemErr_s),
        .StallCount(StallCount_s), .FlushCount(FlushCount_s), .MemState(MemState_s)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic logic [12:0] mk(input logic st, input logic [1:0] fa, input logic [1:0] fb,
                                       input logic sf, input logic sd, input logic se, input logic sm,
                                       input logic fd, input logic fe, input logic fw, input logic me);
        return {st, fa, fb, sf, sd, se, sm, fd, fe, fw, me};
    endfunction

    function automatic in_t idle_in();
        in_t v;
        v.ra1d = '0; v.ra2d = '0; v.ra1e = '0; v.ra2e = '0;
        v.wa3e = '0; v.wa3m = '0; v.wa3w = '0;
        v.regwritem = 0; v.regwritew = 0; v.memtorege = 0; v.pcwrpendingf = 0;
        v.pcsrcw = 0; v.branchtakene = 0; v.memreqm = 0; v.memreadym = 0;
        return v;
    endfunction

    function automatic logic [1:0] mfwd(input logic rwm, input logic [3:0] wam,
                                        input logic rww, input logic [3:0] waw,
                                        input logic [3:0] ra);
        if (ra == 4'd15) return 2'b00;
        if (rwm && wam == ra) return 2'b10;
        if (rww && waw == ra) return 2'b01;
        return 2'b00;
    endfunction

    // Expected outputs in RUN with no memory access outstanding
    function automatic logic [12:0] model_run(input in_t v);
        logic ldr, sf, sd, fd, fe;
        ldr = v.memtorege && ((v.ra1d == v.wa3e) || (v.ra2d == v.wa3e));
        sf  = (ldr || v.pcwrpendingf) && !v.branchtakene;
        sd  = ldr && !v.branchtakene;
        fd  = v.pcwrpendingf || v.pcsrcw || v.branchtakene;
        fe  = ldr || v.branchtakene;
        return mk(1'b0, mfwd(v.regwritem, v.wa3m, v.regwritew, v.wa3w, v.ra1e),
                  mfwd(v.regwritem, v.wa3m, v.regwritew, v.wa3w, v.ra2e),
                  sf, sd, 1'b0, 1'b0, fd, fe, 1'b0, 1'b0);
    endfunction

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input in_t v);
        RA1D = v.ra1d; RA2D = v.ra2d; RA1E = v.ra1e; RA2E = v.ra2e;
        WA3E = v.wa3e; WA3M = v.wa3m; WA3W = v.wa3w;
        RegWriteM = v.regwritem; RegWriteW = v.regwritew; MemtoRegE = v.memtorege;
        PCWrPendingF = v.pcwrpendingf; PCSrcW = v.pcsrcw; BranchTakenE = v.branchtakene;
        MemReqM = v.memreqm; MemReadyM = v.memreadym;
    endtask

    // Drive one cycle, push expectation, pop and compare at the falling edge
    task automatic step(input in_t v, input logic [12:0] e, input string name);
        logic [12:0] want;
        @(posedge clk); #1;
        drive(v);
        exp_q.push_back(e);
        if (e[7]) exp_stall++;
        if (e[2]) exp_flush++;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check_val({name, "_sb_underflow"}, 32'd1, 32'd0);
        end else begin
            want = exp_q.pop_front();
            check_val(name, {19'd0, act}, {19'd0, want});
        end
    endtask

    task automatic do_reset(input string name);
        in_t v;
        v = idle_in();
        v.ra1e = 4'd3; v.wa3m = 4'd3; v.regwritem = 1;
        v.ra2e = 4'd4; v.wa3w = 4'd4; v.regwritew = 1;
        v.pcwrpendingf = 1; v.memtorege = 1; v.memreqm = 1;
        @(posedge clk); #1;
        reset = 1'b0;
        drive(v);
        #1;
        check_val({name, "_state_async"}, {31'd0, MemState}, 32'd0);
        @(negedge clk);
        check_val({name, "_outs"}, {19'd0, act}, {19'd0, mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 1, 1, 0)});
        check_val({name, "_cnts"}, {StallCount, FlushCount}, 32'd0);
        check_val({name, "_small"}, {22'd0, MemState_s, MemErr_s, StallCount_s, FlushCount_s}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        drive(idle_in());
        exp_stall = 0;
        exp_flush = 0;
    endtask

    // ---------------- test ----------------
    vec_t tbl[15];

    initial begin
        in_t v;
        for (int i = 0; i < 15; i++) tbl[i].in = idle_in();
        tbl[0].in.ra1e = 3; tbl[0].in.wa3m = 3; tbl[0].in.regwritem = 1;
        tbl[0].exp = mk(0, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1].in = tbl[0].in; tbl[1].in.wa3w = 3; tbl[1].in.regwritew = 1;
        tbl[1].exp = mk(0, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[2].in = tbl[1].in; tbl[2].in.ra1e = 15; tbl[2].in.wa3m = 15; tbl[2].in.wa3w = 15;
        tbl[2].exp = mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[3].in.ra1e = 4; tbl[3].in.wa3w = 4; tbl[3].in.regwritew = 1;
        tbl[3].in.wa3m = 3; tbl[3].in.regwritem = 1;
        tbl[3].exp = mk(0, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[4].in.ra1e = 2; tbl[4].in.ra2e = 7; tbl[4].in.wa3m = 7; tbl[4].in.wa3w = 7;
        tbl[4].in.regwritew = 1;
        tbl[4].exp = mk(0, 2'b00, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[5].in.ra1e = 9; tbl[5].in.ra2e = 9; tbl[5].in.wa3m = 9; tbl[5].in.regwritem = 1;
        tbl[5].exp = mk(0, 2'b10, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[6].in.memtorege = 1; tbl[6].in.wa3e = 5; tbl[6].in.ra2d = 5; tbl[6].in.ra1d = 1;
        tbl[6].exp = mk(0, 2'b00, 2'b00, 1, 1, 0, 0, 0, 1, 0, 0);
        tbl[7].in = tbl[6].in; tbl[7].in.branchtakene = 1;
        tbl[7].exp = mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 1, 0, 0);
        tbl[8].in.memtorege = 1; tbl[8].in.wa3e = 6; tbl[8].in.ra1d = 6; tbl[8].in.ra2d = 2;
        tbl[8].exp = mk(0, 2'b00, 2'b00, 1, 1, 0, 0, 0, 1, 0, 0);
        tbl[9].in.memtorege = 1; tbl[9].in.wa3e = 5; tbl[9].in.ra1d = 1; tbl[9].in.ra2d = 2;
        tbl[9].exp = mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[10].in.pcwrpendingf = 1;
        tbl[10].exp = mk(0, 2'b00, 2'b00, 1, 0, 0, 0, 1, 0, 0, 0);
        tbl[11].in.pcwrpendingf = 1; tbl[11].in.branchtakene = 1;
        tbl[11].exp = mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 1, 0, 0);
        tbl[12].in.pcsrcw = 1;
        tbl[12].exp = mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0);
        tbl[13].in.memreqm = 1; tbl[13].in.memreadym = 1;
        tbl[13].exp = mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[14].exp = mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);

        drive(idle_in());
        do_reset("reset0");

        // Table vectors
        for (int i = 0; i < 15; i++) step(tbl[i].in, tbl[i].exp, $sformatf("tbl%0d", i));

        // Random RUN-state vectors against the spec model
        for (int i = 0; i < 30; i++) begin
            v = idle_in();
            v.ra1d = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
            v.ra2d = 4'($urandom_range(0, 3));
            v.ra1e = ($urandom_range(0, 5) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
            v.ra2e = ($urandom_range(0, 5) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
            v.wa3e = 4'($urandom_range(0, 3));
            v.wa3m = ($urandom_range(0, 5) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
            v.wa3w = ($urandom_range(0, 5) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
            v.regwritem = 1'($urandom_range(0, 1));
            v.regwritew = 1'($urandom_range(0, 1));
            v.memtorege = 1'($urandom_range(0, 1));
            v.pcwrpendingf = ($urandom_range(0, 3) == 0);
            v.pcsrcw = ($urandom_range(0, 3) == 0);
            v.branchtakene = ($urandom_range(0, 3) == 0);
            step(v, model_run(v), $sformatf("rnd%0d", i));
        end
        step(idle_in(), mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0), "idle_a");
        check_val("cnt_stall_table", {16'd0, StallCount}, exp_stall);
        check_val("cnt_flush_table", {16'd0, FlushCount}, exp_flush);

        // Memory wait released by ready on the 4th cycle; branch frozen meanwhile
        do_reset("reset1");
        v = idle_in(); v.memreqm = 1;
        step(v, mk(0, 2'b00, 2'b00, 1, 1, 1, 1, 0, 0, 1, 0), "mw1");
        v.branchtakene = 1; v.pcsrcw = 1;
        step(v, mk(1, 2'b00, 2'b00, 1, 1, 1, 1, 0, 0, 1, 0), "mw2");
        v.branchtakene = 0; v.pcsrcw = 0;
        step(v, mk(1, 2'b00, 2'b00, 1, 1, 1, 1, 0, 0, 1, 0), "mw3");
        v.memreadym = 1;
        step(v, mk(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0), "mw4");
        step(idle_in(), mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0), "mw5");
        check_val("mw_stallcount", {16'd0, StallCount}, 32'd3);
        check_val("mw_flushcount", {16'd0, FlushCount}, 32'd0);
        check_val("mw_small_err", {31'd0, MemErr_s}, 32'd0);

        // PC write pending then PC write in Writeback
        do_reset("reset2");
        v = idle_in(); v.pcwrpendingf = 1;
        for (int i = 0; i < 3; i++)
            step(v, mk(0, 2'b00, 2'b00, 1, 0, 0, 0, 1, 0, 0, 0), $sformatf("pcw%0d", i));
        v = idle_in(); v.pcsrcw = 1;
        step(v, mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0), "pcsrcw");
        step(idle_in(), mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0), "pcw_idle");
        check_val("pcw_stallcount", {16'd0, StallCount}, 32'd3);
        check_val("pcw_flushcount", {16'd0, FlushCount}, 32'd0);

        // Counter saturation on the 4-bit instance
        do_reset("reset3");
        v = idle_in(); v.pcwrpendingf = 1;
        for (int i = 0; i < 20; i++)
            step(v, mk(0, 2'b00, 2'b00, 1, 0, 0, 0, 1, 0, 0, 0), $sformatf("sat%0d", i));
        step(idle_in(), mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0), "sat_idle");
        check_val("sat_small_15", {28'd0, StallCount_s}, 32'd15);
        check_val("sat_big_20", {16'd0, StallCount}, 32'd20);
        for (int i = 0; i < 3; i++)
            step(v, mk(0, 2'b00, 2'b00, 1, 0, 0, 0, 1, 0, 0, 0), $sformatf("sat_more%0d", i));
        step(idle_in(), mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0), "sat_idle2");
        check_val("sat_small_hold", {28'd0, StallCount_s}, 32'd15);
        check_val("sat_big_23", {16'd0, StallCount}, 32'd23);

        // Timeout on the MEM_TIMEOUT=4 instance, then reset mid-WAIT on the default one
        do_reset("reset4");
        v = idle_in(); v.memreqm = 1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            drive(v);
            @(negedge clk);
            check_val($sformatf("to_stall%0d", k), {31'd0, StallF_s}, (k <= 4) ? 32'd1 : 32'd0);
            check_val($sformatf("to_flushw%0d", k), {31'd0, FlushW_s}, (k <= 4) ? 32'd1 : 32'd0);
            check_val($sformatf("to_err%0d", k), {31'd0, MemErr_s}, 32'd0);
            check_val($sformatf("to_big_stall%0d", k), {31'd0, StallF}, 32'd1);
        end
        for (int k = 6; k <= 8; k++) begin
            @(posedge clk); #1;
            drive(idle_in());
            @(negedge clk);
            check_val($sformatf("to_err_sticky%0d", k), {31'd0, MemErr_s}, 32'd1);
            check_val($sformatf("to_small_run%0d", k), {31'd0, MemState_s}, 32'd0);
            check_val($sformatf("to_big_wait%0d", k), {31'd0, MemState}, 32'd1);
        end
        check_val("to_small_cnt", {28'd0, StallCount_s}, 32'd4);
        do_reset("reset_midwait");
        step(idle_in(), mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0), "post_reset");

        check_val("sb_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
